calibration_sequencer: RTL and testbench

//  Autonomous sequencer for the LED calibration manager. On start it enables calibration,

---
 rtl/calibration_sequencer.sv | 162 ++++++++++++++++
 tb/tb_calibration_sequencer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/calibration_sequencer.sv
// Autonomous LED calibration sweep: walks IDs 0..NUM_LEDS-1, waits for each ID frame to show,
// lets the camera settle, requests a capture, waits one full camera frame, then advances.
module calibration_sequencer #(
    parameter int unsigned NUM_LEDS          = 50,
    parameter int unsigned LED_ADDRESS_WIDTH = $clog2(NUM_LEDS),
    parameter int unsigned SETTLE_FRAMES     = 2,
    parameter int unsigned TIMEOUT_CYCLES    = 2_000_000
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         start_i,
    input  logic                         abort_i,
    input  logic                         displayed_frame_valid_i,
    input  logic                         frame_start_i,
    output logic                         calibration_on_o,
    output logic                         increment_id_o,
    output logic                         capture_shown_frame_o,
    output logic [LED_ADDRESS_WIDTH:0]   current_id_o,
    output logic                         busy_o,
    output logic                         done_o,
    output logic                         error_o
);

    localparam int unsigned IdW      = LED_ADDRESS_WIDTH + 1;
    localparam int unsigned FrameMax = (SETTLE_FRAMES > 2) ? SETTLE_FRAMES : 2;
    localparam int unsigned FcntW    = $clog2(FrameMax + 1);
    localparam int unsigned TmrW     = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [IdW-1:0]   LastId        = IdW'(NUM_LEDS - 1);
    localparam logic [FcntW-1:0] FcntSat       = FcntW'(FrameMax);
    localparam logic [FcntW-1:0] SettleTarget  = FcntW'(SETTLE_FRAMES);
    localparam logic [FcntW-1:0] CaptureTarget = FcntW'(2);
    localparam logic [TmrW-1:0]  TimeoutLast   = TmrW'(TIMEOUT_CYCLES - 1);

    localparam logic [3:0] StIdle        = 4'd0;
    localparam logic [3:0] StWaitLow     = 4'd1;
    localparam logic [3:0] StWaitShown   = 4'd2;
    localparam logic [3:0] StSettle      = 4'd3;
    localparam logic [3:0] StCapture     = 4'd4;
    localparam logic [3:0] StWaitCapture = 4'd5;
    localparam logic [3:0] StAdvance     = 4'd6;
    localparam logic [3:0] StDone        = 4'd7;
    localparam logic [3:0] StError       = 4'd8;

    logic [3:0]       state_q, state_d;
    logic [IdW-1:0]   id_q, id_d;
    logic [FcntW-1:0] fcnt_q, fcnt_d, fcnt_inc;
    logic [TmrW-1:0]  tmr_q, tmr_d;
    logic             cal_on_q, cal_on_d;
    logic             inc_q, inc_d;
    logic             cap_q, cap_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             waiting, counting, timed_out, entering;

    assign waiting  = (state_q == StWaitLow) || (state_q == StWaitShown) ||
                      (state_q == StSettle) || (state_q == StWaitCapture);
    assign counting = (state_q == StSettle) || (state_q == StWaitCapture);
    assign timed_out = waiting && (tmr_q == TimeoutLast);
    assign fcnt_inc = (frame_start_i && (fcnt_q != FcntSat)) ? fcnt_q + FcntW'(1) : fcnt_q;

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        inc_d   = 1'b0;
        if (abort_i) begin
            state_d = StIdle;
            id_d    = '0;
        end else if (timed_out) begin
            state_d = StError;
        end else begin
            case (state_q)
                StIdle, StDone, StError: begin
                    if (start_i) begin
                        state_d = StWaitLow;
                        id_d    = '0;
                    end
                end
                // ID 0 has no predecessor frame, so there is no stale valid to drain.
                StWaitLow: begin
                    if ((id_q == '0) || !displayed_frame_valid_i) state_d = StWaitShown;
                end
                StWaitShown: begin
                    if (displayed_frame_valid_i) begin
                        state_d = (SETTLE_FRAMES == 0) ? StCapture : StSettle;
                    end
                end
                StSettle: begin
                    if (fcnt_inc >= SettleTarget) state_d = StCapture;
                end
                StCapture: state_d = StWaitCapture;
                StWaitCapture: begin
                    if (fcnt_inc >= CaptureTarget) state_d = StAdvance;
                end
                StAdvance: begin
                    if (id_q == LastId) begin
                        state_d = StDone;
                    end else begin
                        state_d = StWaitLow;
                        id_d    = id_q + IdW'(1);
                        inc_d   = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Both counters restart on every state change so each wait is measured from its own entry.
    assign entering = (state_d != state_q);

    always_comb begin
        fcnt_d = '0;
        tmr_d  = '0;
        if (!entering && counting) fcnt_d = fcnt_inc;
        if (!entering && waiting) tmr_d = (tmr_q == TimeoutLast) ? tmr_q : tmr_q + TmrW'(1);
    end

    always_comb begin
        busy_d   = !((state_d == StIdle) || (state_d == StDone) || (state_d == StError));
        cal_on_d = busy_d;
        done_d   = (state_d == StDone);
        err_d    = (state_d == StError);
        cap_d    = (state_d == StCapture);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            id_q     <= '0;
            fcnt_q   <= '0;
            tmr_q    <= '0;
            cal_on_q <= 1'b0;
            inc_q    <= 1'b0;
            cap_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            id_q     <= id_d;
            fcnt_q   <= fcnt_d;
            tmr_q    <= tmr_d;
            cal_on_q <= cal_on_d;
            inc_q    <= inc_d;
            cap_q    <= cap_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign calibration_on_o      = cal_on_q;
    assign increment_id_o        = inc_q;
    assign capture_shown_frame_o = cap_q;
    assign current_id_o          = id_q;
    assign busy_o                = busy_q;
    assign done_o                = done_q;
    assign error_o               = err_q;

endmodule

// File: tb/tb_calibration_sequencer.sv
// Bench for calibration_sequencer: a cycle table, directed corner sequences, and randomized
// full sweeps checked against event-time predictions derived from the frame timing.
module tb_calibration_sequencer;

    localparam int NL = 4;
    localparam int TO = 1000;

    logic       clk = 1'b0;
    logic       rst, start, abort, valid, fs;
    logic       cal, inc, cap, busy, done, err;
    logic [2:0] id;

    calibration_sequencer #(
        .NUM_LEDS         (NL),
        .LED_ADDRESS_WIDTH(2),
        .SETTLE_FRAMES    (2),
        .TIMEOUT_CYCLES   (TO)
    ) dut (
        .clk_i                  (clk),
        .rst_i                  (rst),
        .start_i                (start),
        .abort_i                (abort),
        .displayed_frame_valid_i(valid),
        .frame_start_i          (fs),
        .calibration_on_o       (cal),
        .increment_id_o         (inc),
        .capture_shown_frame_o  (cap),
        .current_id_o           (id),
        .busy_o                 (busy),
        .done_o                 (done),
        .error_o                (err)
    );

    always #5 clk = ~clk;

    int cyc = 0, n_cmp = 0, n_bad = 0, cap_cnt = 0, inc_cnt = 0;
    // Frame generator (period 0 = bench drives fs by hand) and manager model (mode 0 auto,
    // 1 = valid stuck high, 2 = bench drives valid by hand).
    int fs_per = 0, fs_ph = 0, mgr_mode = 2, mgr_low = 5, low_left = 0;

    typedef struct {
        logic       st, ab, v, f;
        logic [5:0] flg;  // {cal, busy, cap, inc, done, err}
        int         id;
    } vec_t;
    vec_t tbl[15];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic int flags();
        return int'({cal, busy, cap, inc, done, err});
    endfunction

    // First frame_start cycle at or after x.
    function automatic int nf(input int x);
        return x + ((fs_ph - (x % fs_per) + fs_per) % fs_per);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (cap) cap_cnt++;
        if (inc) inc_cnt++;
        start = 1'b0;
        abort = 1'b0;
        if (fs_per > 0) fs = ((cyc % fs_per) == fs_ph);
        if (mgr_mode == 0) begin
            if (inc) low_left = mgr_low;
            if (low_left > 0) begin
                valid = 1'b0;
                low_left--;
            end else begin
                valid = 1'b1;
            end
        end else if (mgr_mode == 1) begin
            valid = 1'b1;
        end
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) tick();
    endtask

    // Predicts each capture / advance from frame times: settling starts the cycle after valid
    // is seen, capture follows the 2nd counted frame by one cycle, and the capture frame ends
    // at the 2nd frame_start after the capture cycle.
    task automatic run_sweep(input int p, input int ph, input int d, input int abort_id);
        int nxt, c, q, c0, i0;
        fs_per = p; fs_ph = ph; mgr_low = d; mgr_mode = 0; low_left = 0; valid = 1'b1;
        c0 = cap_cnt; i0 = inc_cnt;
        start = 1'b1;
        nxt = cyc + 3;
        for (int k = 0; k < NL; k++) begin
            c = nf(nxt) + p + 1;
            wait_until(c);
            chk("sweep_capture", int'(cap), 1);
            chk("sweep_capture_id", int'(id), k);
            q = nf(c + 1) + p;
            if (k == abort_id) begin
                wait_until(q);
                abort = 1'b1;
                i0 = inc_cnt;
                tick();
                chk("abort_flags", flags(), 0);
                chk("abort_id", int'(id), 0);
                repeat (6) tick();
                chk("abort_no_inc", inc_cnt - i0, 0);
                chk("abort_stays_idle", int'(busy), 0);
                return;
            end
            wait_until(q + 2);
            if (k < NL - 1) begin
                chk("sweep_increment", int'(inc), 1);
                chk("sweep_next_id", int'(id), k + 1);
                nxt = q + 2 + d + 1;
            end else begin
                chk("sweep_done_flags", flags(), 6'b000010);
                chk("sweep_final_id", int'(id), NL - 1);
            end
        end
        chk("sweep_captures", cap_cnt - c0, NL);
        chk("sweep_increments", inc_cnt - i0, NL - 1);
    endtask

    initial begin
        int t, k, got, c0, p, ph;
        rst = 1'b1; start = 1'b0; abort = 1'b0; valid = 1'b0; fs = 1'b0;
        repeat (3) tick();
        chk("reset_flags", flags(), 0);
        chk("reset_id", int'(id), 0);
        rst = 1'b0;

        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 6'b110000, 0};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 6'b110000, 0};
        tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 6'b110000, 0};
        tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 6'b110000, 0};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 6'b110000, 0};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 6'b111000, 0};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 6'b110000, 0};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 6'b110000, 0};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 6'b110000, 0};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 6'b110100, 1};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 6'b110000, 1};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 6'b110000, 1};
        tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 6'b110000, 1};
        tbl[13] = '{1'b0, 1'b1, 1'b1, 1'b0, 6'b000000, 0};
        tbl[14] = '{1'b1, 1'b1, 1'b0, 1'b0, 6'b000000, 0};
        for (int i = 0; i < 15; i++) begin
            start = tbl[i].st; abort = tbl[i].ab; valid = tbl[i].v; fs = tbl[i].f;
            tick();
            chk($sformatf("table_flags_%0d", i), flags(), int'(tbl[i].flg));
            chk($sformatf("table_id_%0d", i), int'(id), tbl[i].id);
        end

        run_sweep(50, 7, 5, 99);
        run_sweep(50, 13, 5, 1);
        for (int r = 0; r < 6; r++) begin
            p  = int'($urandom_range(60, 3));
            ph = int'($urandom_range(p - 1, 0));
            run_sweep(p, ph, int'($urandom_range(8, 1)), 99);
        end

        // Settle count: the pulse coinciding with valid's rise is not counted.
        fs_per = 0; fs = 1'b0; mgr_mode = 2; valid = 1'b0;
        start = 1'b1;
        repeat (5) tick();
        valid = 1'b1; fs = 1'b1; t = cyc;
        c0 = cap_cnt;
        for (int i = 0; i < 105; i++) begin
            tick();
            fs = ((cyc - t) == 50) || ((cyc - t) == 100);
            if ((cyc - t) == 51) chk("settle_not_early", int'(cap), 0);
            if ((cyc - t) == 101) chk("settle_capture", int'(cap), 1);
        end
        chk("settle_one_capture", cap_cnt - c0, 1);
        abort = 1'b1;
        tick();
        chk("settle_abort_flags", flags(), 0);

        // Stale valid held high across increment_id must stall and then time out.
        fs_per = 20; fs_ph = 0; mgr_mode = 1;
        start = 1'b1;
        got = 0;
        for (int i = 0; i < 400 && got == 0; i++) begin
            tick();
            if (inc) got = 1;
        end
        chk("stale_increment_seen", got, 1);
        k = cyc; c0 = cap_cnt;
        wait_until(k + TO - 1);
        chk("stale_no_error_yet", int'(err), 0);
        chk("stale_no_capture", cap_cnt - c0, 0);
        tick();
        chk("stale_error_flags", flags(), 6'b000001);
        chk("stale_error_id", int'(id), 1);

        // Timeout in SETTLE at ID 2, then restart from ERROR.
        fs_per = 30; fs_ph = 3; mgr_mode = 0; mgr_low = 5; low_left = 0; valid = 1'b1;
        start = 1'b1;
        got = 0;
        for (int i = 0; i < 1000 && got == 0; i++) begin
            tick();
            if (inc && id == 3'd2) got = 1;
        end
        chk("err2_reached_id2", got, 1);
        k = cyc; fs_per = 0; fs = 1'b0;
        got = 0;
        for (int i = 0; i < 1200 && got == 0; i++) begin
            tick();
            if (err) got = 1;
        end
        chk("err2_timeout_cycle", cyc - k, 5 + 1 + TO);
        chk("err2_flags", flags(), 6'b000001);
        chk("err2_id", int'(id), 2);
        start = 1'b1;
        tick();
        chk("restart_flags", flags(), 6'b110000);
        chk("restart_id", int'(id), 0);

        repeat (3) tick();
        c0 = inc_cnt;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_flags", flags(), 0);
        chk("rst_mid_id", int'(id), 0);
        chk("rst_mid_no_inc", inc_cnt - c0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: got timeout expected completion at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
